// File: rtl/ofmap_stream_writer_if.sv
// Handshake bundle between the accelerator output path, the ofmap writer and the dump sink.
// master drives the source word and sink ready; slave is the writer itself.
interface ofmap_stream_writer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 20
);
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [COUNT_WIDTH-1:0] out_index;
  logic                   out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/ofmap_stream_writer.sv
// Buffers accelerator ofmap words in a small FIFO and emits them to the dump sink in line
// order with a 1-based line index, tracking frame completion and surplus input words.
module ofmap_stream_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [COUNT_WIDTH-1:0] i_numWords,
  ofmap_stream_writer_if.slave   io_stream,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_extraErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wrPtr;
  logic [AW:0]            r_rdPtr;
  logic [COUNT_WIDTH-1:0] r_numWords;
  logic [COUNT_WIDTH-1:0] r_accepted;
  logic [COUNT_WIDTH-1:0] r_emitted;
  logic                   r_extraErr;

  logic w_empty;
  logic w_full;
  logic w_active;
  logic w_allAccepted;
  logic w_inReady;
  logic w_outValid;
  logic w_push;
  logic w_pop;
  logic w_launch;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_empty       = (r_wrPtr == r_rdPtr);
  assign w_full        = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_active      = (r_state == STREAM) || (r_state == DRAIN);
  assign w_allAccepted = (r_accepted == r_numWords);
  assign w_inReady     = (r_state == STREAM) && !w_full && !w_allAccepted;
  assign w_outValid    = w_active && !w_empty;
  assign w_push        = io_stream.in_valid && w_inReady;
  assign w_pop         = w_outValid && io_stream.out_ready;
  assign w_launch      = i_start && ((r_state == IDLE) || (r_state == DONE));

  assign io_stream.in_ready  = w_inReady;
  assign io_stream.out_valid = w_outValid;
  assign io_stream.out_data  = w_outValid ? r_mem[r_rdPtr[AW-1:0]] : '0;
  assign io_stream.out_index = r_emitted + ONE;
  assign o_busy              = w_active;
  assign o_done              = (r_state == DONE);
  assign o_extraErr          = r_extraErr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_launch) begin
          w_nextState = (i_numWords == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (w_push && ((r_accepted + ONE) == r_numWords)) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && ((r_emitted + ONE) == r_numWords)) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A new frame flushes the FIFO and counters; surplus words are only flagged, never stored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_numWords <= '0;
      r_accepted <= '0;
      r_emitted  <= '0;
      r_extraErr <= 1'b0;
    end else if (w_launch) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_numWords <= i_numWords;
      r_accepted <= '0;
      r_emitted  <= '0;
      r_extraErr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr    <= r_wrPtr + PTR_ONE;
        r_accepted <= r_accepted + ONE;
      end
      if (w_pop) begin
        r_rdPtr   <= r_rdPtr + PTR_ONE;
        r_emitted <= r_emitted + ONE;
      end
      if (w_active && io_stream.in_valid && w_allAccepted) begin
        r_extraErr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= io_stream.in_data;
    end
  end

endmodule

// File: tb/tb_ofmap_stream_writer.sv
// Directed self-checking bench for ofmap_stream_writer: a negedge monitor collects emitted
// words and checks stall stability, and each frame is compared against the stimulus table.
module tb_ofmap_stream_writer;

  localparam int DW = 16;
  localparam int CW = 20;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] numWords;
  logic          busy;
  logic          done;
  logic          extraErr;

  ofmap_stream_writer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) streamIf ();

  ofmap_stream_writer #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .i_numWords (numWords),
    .io_stream  (streamIf.slave),
    .o_busy     (busy),
    .o_done     (done),
    .o_extraErr (extraErr)
  );

  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;
  int cyc         = 0;

  logic [DW-1:0] stimWords [0:999];
  logic [DW-1:0] popData [$];
  logic [CW-1:0] popIndex [$];
  int            srcIdx;
  int            startCyc;
  int            firstAcceptCyc;
  int            firstValidCyc;
  int            lastPopCyc;
  int            doneCyc;
  bit            firstAcceptSeen;
  bit            firstValidSeen;
  bit            busySeen;
  bit            holdValid;
  logic [DW-1:0] heldData;
  logic [CW-1:0] heldIndex;

  always @(posedge clk) cyc <= cyc + 1;

  // Every comparison in the bench funnels through here
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Monitor: records handshakes due at the coming edge and checks held words stay put
  always @(negedge clk) begin
    if (reset) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid && streamIf.out_valid) begin
        checkOutput("holdData", streamIf.out_data, heldData);
        checkOutput("holdIndex", streamIf.out_index, heldIndex);
      end
      if (streamIf.out_valid && !firstValidSeen) begin
        firstValidSeen = 1'b1;
        firstValidCyc  = cyc;
      end
      if (busy) busySeen = 1'b1;
      if (streamIf.out_valid && streamIf.out_ready) begin
        popData.push_back(streamIf.out_data);
        popIndex.push_back(streamIf.out_index);
        lastPopCyc = cyc;
      end
      holdValid = streamIf.out_valid && !streamIf.out_ready;
      heldData  = streamIf.out_data;
      heldIndex = streamIf.out_index;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".in_ready"}, streamIf.in_ready, 0);
    checkOutput({tag, ".out_valid"}, streamIf.out_valid, 0);
    checkOutput({tag, ".out_data"}, streamIf.out_data, 0);
    checkOutput({tag, ".out_index"}, streamIf.out_index, 1);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".extra_err"}, extraErr, 0);
  endtask

  task automatic startFrame(input int n);
    popData.delete();
    popIndex.delete();
    srcIdx          = 0;
    firstAcceptSeen = 1'b0;
    firstValidSeen  = 1'b0;
    busySeen        = 1'b0;
    start           = 1'b1;
    numWords        = CW'(n);
    tick();
    start    = 1'b0;
    startCyc = cyc;
  endtask

  // Drives the source table and sink ready until done, a pop target, or the cycle budget
  task automatic applyStimulus(input int nPresent, input int validPct, input int readyPct,
                               input int stopPops, input int budget);
    int n = 0;
    while (!done && popData.size() < stopPops && n < budget) begin
      streamIf.in_valid  = (srcIdx < nPresent) && ($urandom_range(99) < validPct);
      streamIf.in_data   = (srcIdx < nPresent) ? stimWords[srcIdx] : '0;
      streamIf.out_ready = ($urandom_range(99) < readyPct);
      @(negedge clk);
      if (streamIf.in_valid && streamIf.in_ready) begin
        if (!firstAcceptSeen) begin
          firstAcceptSeen = 1'b1;
          firstAcceptCyc  = cyc;
        end
        srcIdx++;
      end
      tick();
      n++;
    end
    doneCyc            = cyc;
    streamIf.in_valid  = 1'b0;
    streamIf.out_ready = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input int nExp);
    checkOutput({tag, ".popCount"}, popData.size(), nExp);
    for (int i = 0; i < popData.size() && i < nExp; i++) begin
      checkOutput($sformatf("%s.data[%0d]", tag, i), popData[i], stimWords[i]);
      checkOutput($sformatf("%s.index[%0d]", tag, i), popIndex[i], i + 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    start              = 1'b0;
    numWords           = '0;
    streamIf.in_valid  = 1'b0;
    streamIf.in_data   = '0;
    streamIf.out_ready = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();

    // Five back-to-back words with the sink always ready
    for (int i = 0; i < 5; i++) stimWords[i] = DW'(i + 1);
    startFrame(5);
    checkOutput("t1.busyAfterStart", busy, 1);
    applyStimulus(5, 100, 100, BIG, 100);
    checkOutput("t1.done", done, 1);
    checkOutput("t1.busyInDone", busy, 0);
    checkOutput("t1.firstAccept", firstAcceptCyc, startCyc);
    checkOutput("t1.firstValid", firstValidCyc, firstAcceptCyc + 1);
    checkOutput("t1.doneCycle", doneCyc, lastPopCyc + 1);
    checkFrame("t1", 5);

    // Sink stalled: the FIFO must fill to exactly eight entries and then block the source
    for (int i = 0; i < 20; i++) stimWords[i] = DW'(16'h0100 + i);
    startFrame(20);
    for (int c = 0; c < 30; c++) begin
      streamIf.in_valid  = 1'b1;
      streamIf.in_data   = stimWords[srcIdx];
      streamIf.out_ready = 1'b0;
      @(negedge clk);
      if (streamIf.in_valid && streamIf.in_ready) srcIdx++;
      tick();
    end
    checkOutput("t2.acceptsWhileFull", srcIdx, 8);
    checkOutput("t2.inReadyFull", streamIf.in_ready, 0);
    checkOutput("t2.outValidFull", streamIf.out_valid, 1);
    checkOutput("t2.headData", streamIf.out_data, 16'h0100);
    applyStimulus(20, 100, 100, BIG, 200);
    checkOutput("t2.done", done, 1);
    checkFrame("t2", 20);

    // Source offers one word too many: it is flagged and never emitted
    for (int i = 0; i < 4; i++) stimWords[i] = DW'(16'hA000 + i);
    startFrame(3);
    applyStimulus(4, 100, 100, BIG, 100);
    checkOutput("t3.done", done, 1);
    checkOutput("t3.extraErr", extraErr, 1);
    checkFrame("t3", 3);
    tick();
    tick();
    checkOutput("t3.extraErrSticky", extraErr, 1);
    checkOutput("t3.noOutValid", streamIf.out_valid, 0);
    stimWords[0] = 16'h5A5A;
    startFrame(1);
    checkOutput("t3.extraErrCleared", extraErr, 0);
    applyStimulus(1, 100, 100, BIG, 100);
    checkFrame("t3b", 1);

    // Empty frame goes straight to done
    startFrame(0);
    checkOutput("t4.done", done, 1);
    checkOutput("t4.busy", busy, 0);
    checkOutput("t4.outValid", streamIf.out_valid, 0);
    tick();
    tick();
    checkOutput("t4.busyNeverHigh", busySeen, 0);
    checkOutput("t4.noPops", popData.size(), 0);

    // Long frame with random source and sink pacing
    for (int i = 0; i < 1000; i++) stimWords[i] = DW'((i * 40503 + 17) & 16'hFFFF);
    startFrame(1000);
    applyStimulus(1000, 50, 50, BIG, 20000);
    checkOutput("t5.done", done, 1);
    checkOutput("t5.srcConsumed", srcIdx, 1000);
    checkFrame("t5", 1000);

    // Reset in the middle of a frame discards buffered words
    for (int i = 0; i < 10; i++) stimWords[i] = DW'(16'hC000 + i);
    startFrame(10);
    applyStimulus(10, 100, 100, 4, 100);
    checkFrame("t6pre", 4);
    reset = 1'b1;
    tick();
    checkResetValues("t6reset");
    reset = 1'b0;
    tick();
    stimWords[0] = 16'hD000;
    stimWords[1] = 16'hD001;
    startFrame(2);
    applyStimulus(2, 100, 100, BIG, 100);
    checkOutput("t6.done", done, 1);
    checkFrame("t6post", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
